reg_shift_sequencer: RTL and testbench

Multi-cycle controller for register-specified shifts, where the shift amount comes from Rs[7:0]. The Val2 generator only resolves immediate-amount shifts in a single cycle. This block sits beside it in the execute stage. It accepts Rm, the shift type and Rs[7:0], iterates the shift STEP bits per cycle, and applies the ARM boundary rules for amounts 0 and ≥32. It stalls the pipeline through the hazard path until the result and shifter carry-out are valid.

---
 rtl/reg_shift_sequencer_pkg.sv | 19 +
 rtl/reg_shift_sequencer_shift_step_unit.sv | 58 +++++
 rtl/reg_shift_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reg_shift_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_shift_sequencer_pkg.sv
// reg_shift_sequencer_pkg
//
// Items shared by the register-amount shift sequencer and the Val2 generator:
//   SH_LSL / SH_LSR / SH_ASR / SH_ROR : two-bit shift-type encodings
//   state_t                           : sequencer states IDLE / SHIFT / DONE
package reg_shift_sequencer_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/reg_shift_sequencer_shift_step_unit.sv
// shift_step_unit
//
// Combinational single-step shifter. It moves the value by at most STEP bit
// positions in one cycle and reports the last bit shifted out.
//   value      in  32      operand
//   shift_type in  2       SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   amount     in  SW      shift distance, 0..STEP
//   carry_in   in  1       carry returned unchanged when amount is zero
//   result     out 32      shifted value
//   carry      out 1       last bit shifted out (new bit 31 for ROR)
module shift_step_unit
  import reg_shift_sequencer_pkg::*;
#(
  parameter int STEP = 8,
  localparam int SW = $clog2(STEP) + 1
) (
  input  logic [31:0]   value,
  input  logic [1:0]    shift_type,
  input  logic [SW-1:0] amount,
  input  logic          carry_in,
  output logic [31:0]   result,
  output logic          carry
);

  // Each shift runs through a 64-bit window so that the bit leaving the
  // 32-bit operand lands next to the result and can be picked up as carry.
  logic [63:0] wide;

  always_comb begin
    wide   = '0;
    result = value;
    carry  = carry_in;
    case (shift_type)
      SH_LSL: begin
        wide   = {32'b0, value} << amount;
        result = wide[31:0];
        if (amount != '0) carry = wide[32];
      end
      SH_LSR: begin
        wide   = {value, 32'b0} >> amount;
        result = wide[63:32];
        if (amount != '0) carry = wide[31];
      end
      SH_ASR: begin
        wide   = $signed({value, 32'b0}) >>> amount;
        result = wide[63:32];
        if (amount != '0) carry = wide[31];
      end
      default: begin
        // Rotation: the low half of the doubled value shifted right.
        wide   = {value, value} >> amount;
        result = wide[31:0];
        if (amount != '0) carry = wide[31];
      end
    endcase
  end

endmodule

// File: rtl/reg_shift_sequencer.sv
// reg_shift_sequencer
//
// Multi-cycle controller for shifts whose amount comes from Rs[7:0]. Amounts
// of 0 and >=32 (and ROR by a multiple of 32) are resolved in one cycle;
// everything else is iterated STEP bits per cycle while the pipeline stalls.
//   clk        in  1   clock, rising edge
//   rst_n      in  1   asynchronous active-low reset
//   start      in  1   request, sampled only while ready=1
//   flush      in  1   synchronous abort, beats start and every state
//   shift_type in  2   SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   val_rm     in  32  operand Rm
//   rs_amount  in  8   shift amount Rs[7:0]
//   carry_in   in  1   current C flag
//   ready      out 1   not iterating
//   stall      out 1   hazard request to the pipeline
//   done       out 1   val2/carry_out valid this cycle
//   val2       out 32  shifted result, held until the next load
//   carry_out  out 1   shifter carry-out, held with val2
module reg_shift_sequencer
  import reg_shift_sequencer_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [31:0] val_rm,
  input  logic [7:0]  rs_amount,
  input  logic        carry_in,
  output logic        ready,
  output logic        stall,
  output logic        done,
  output logic [31:0] val2,
  output logic        carry_out
);

  localparam int         SW     = $clog2(STEP) + 1;
  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  logic [5:0]  rem_q;
  logic [1:0]  type_q;
  logic [31:0] val_q;
  logic        carry_q;

  logic        accept;
  logic        special;
  logic [31:0] spec_val;
  logic        spec_carry;
  logic [5:0]  iter_rem;
  logic [5:0]  step_amt;
  logic        last_step;
  logic [31:0] step_val;
  logic        step_carry;

  assign accept    = start & ready & ~flush;
  assign step_amt  = (rem_q < STEP_W) ? rem_q : STEP_W;
  assign last_step = (rem_q == step_amt);

  // Boundary classification of the requested amount. Anything that has a
  // fixed answer goes straight to DONE; the rest leaves a 1..31 bit count.
  always_comb begin
    special    = 1'b0;
    spec_val   = val_rm;
    spec_carry = carry_in;
    iter_rem   = rs_amount[5:0];
    if (rs_amount == 8'd0) begin
      special = 1'b1;
    end else begin
      case (shift_type)
        SH_LSL: begin
          if (rs_amount >= 8'd32) begin
            special    = 1'b1;
            spec_val   = '0;
            spec_carry = (rs_amount == 8'd32) ? val_rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (rs_amount >= 8'd32) begin
            special    = 1'b1;
            spec_val   = '0;
            spec_carry = (rs_amount == 8'd32) ? val_rm[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (rs_amount >= 8'd32) begin
            special    = 1'b1;
            spec_val   = {32{val_rm[31]}};
            spec_carry = val_rm[31];
          end
        end
        default: begin
          // Rotations only care about the amount modulo 32.
          iter_rem = {1'b0, rs_amount[4:0]};
          if (rs_amount[4:0] == 5'd0) begin
            special    = 1'b1;
            spec_carry = val_rm[31];
          end
        end
      endcase
    end
  end

  shift_step_unit #(.STEP(STEP)) u_step (
    .value      (val_q),
    .shift_type (type_q),
    .amount     (step_amt[SW-1:0]),
    .carry_in   (carry_q),
    .result     (step_val),
    .carry      (step_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) state_d = special ? DONE : SHIFT;
          else        state_d = IDLE;
        end
        SHIFT:   if (last_step) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control outputs. stall drops in DONE so the pipeline can consume val2.
  always_comb begin
    ready = (state_q != SHIFT);
    stall = (start && state_q == IDLE) || (state_q == SHIFT);
    done  = (state_q == DONE);
  end

  // Datapath: load on accept, one step per SHIFT cycle. A flush freezes
  // val2/carry_out at whatever they held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      type_q  <= SH_LSL;
    end else if (accept) begin
      type_q <= shift_type;
      if (special) begin
        val_q   <= spec_val;
        carry_q <= spec_carry;
        rem_q   <= '0;
      end else begin
        val_q <= val_rm;
        rem_q <= iter_rem;
      end
    end else if (state_q == SHIFT && !flush) begin
      val_q   <= step_val;
      carry_q <= step_carry;
      rem_q   <= rem_q - step_amt;
    end
  end

  assign val2      = val_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// tb_reg_shift_sequencer
//
// Drives directed boundary cases and randomized traffic into
// reg_shift_sequencer and compares every cycle against a transaction-level
// model built from plain shift arithmetic.
module tb_reg_shift_sequencer;
  import reg_shift_sequencer_pkg::*;

  localparam int STEP = 8;

  typedef struct packed {
    logic        special;
    logic [31:0] v;
    logic        c;
    logic [5:0]  amt;
  } cls_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  shift_type;
  logic [31:0] val_rm;
  logic [7:0]  rs_amount;
  logic        carry_in;
  logic        ready;
  logic        stall;
  logic        done;
  logic [31:0] val2;
  logic        carry_out;

  int checks_total  = 0;
  int checks_passed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reg_shift_sequencer #(.STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .shift_type (shift_type),
    .val_rm     (val_rm),
    .rs_amount  (rs_amount),
    .carry_in   (carry_in),
    .ready      (ready),
    .stall      (stall),
    .done       (done),
    .val2       (val2),
    .carry_out  (carry_out)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  // Full shift by a 1..31 amount using ordinary operators.
  function automatic logic [32:0] ref_shift(input logic [1:0] t, input logic [31:0] rm, input int a);
    logic [31:0] v;
    logic        c;
    case (t)
      SH_LSL: begin v = rm << a; c = rm[32 - a]; end
      SH_LSR: begin v = rm >> a; c = rm[a - 1]; end
      SH_ASR: begin v = $signed(rm) >>> a; c = rm[a - 1]; end
      default: begin v = (rm >> a) | (rm << (32 - a)); c = v[31]; end
    endcase
    return {c, v};
  endfunction

  // Architectural result of a register-amount shift plus the bit count left
  // for iteration (zero when the answer is immediate).
  function automatic cls_t classify(input logic [1:0] t, input logic [31:0] rm,
                                    input logic [7:0] n8, input logic cin);
    cls_t        r;
    logic [32:0] full;
    int          n;
    n = int'(n8);
    r.special = 1'b1;
    r.v       = rm;
    r.c       = cin;
    r.amt     = '0;
    if (n == 0) begin
      r.special = 1'b1;
    end else if (t == SH_ROR) begin
      if (n % 32 == 0) r.c = rm[31];
      else begin r.special = 1'b0; r.amt = 6'(n % 32); end
    end else if (n >= 32) begin
      case (t)
        SH_LSL:  begin r.v = '0; r.c = (n == 32) ? rm[0] : 1'b0; end
        SH_LSR:  begin r.v = '0; r.c = (n == 32) ? rm[31] : 1'b0; end
        default: begin r.v = {32{rm[31]}}; r.c = rm[31]; end
      endcase
    end else begin
      r.special = 1'b0;
      r.amt     = 6'(n);
    end
    if (!r.special) begin
      full = ref_shift(t, rm, int'(r.amt));
      r.v  = full[31:0];
      r.c  = full[32];
    end
    return r;
  endfunction

  // Value after p full steps of an iterative operation.
  function automatic logic [32:0] partial_fn(input logic [1:0] t, input logic [31:0] rm,
                                             input int rem, input int p);
    int a;
    if (p <= 0) return {1'b0, rm};
    a = (p * STEP < rem) ? p * STEP : rem;
    if (a == 0) return {1'b0, rm};
    return ref_shift(t, rm, a);
  endfunction

  // Model state: busy_left counts remaining iterating cycles including the
  // current one; j numbers the current iterating cycle from 1.
  int          busy_left   = 0;
  int          j           = 0;
  bit          m_done      = 1'b0;
  bit          carry_known = 1'b1;
  logic [31:0] exp_val     = '0;
  logic        exp_carry   = 1'b0;
  logic [31:0] m_rm        = '0;
  logic [1:0]  m_type      = '0;
  logic [5:0]  m_rem       = '0;
  logic [32:0] m_full      = '0;
  cls_t        cur_cls;
  logic [32:0] cur_part;

  always_comb cur_cls  = classify(shift_type, val_rm, rs_amount, carry_in);
  always_comb cur_part = partial_fn(m_type, m_rm, int'(m_rem), j - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left   <= 0;
      j           <= 0;
      m_done      <= 1'b0;
      exp_val     <= '0;
      exp_carry   <= 1'b0;
      carry_known <= 1'b1;
      m_rm        <= '0;
      m_type      <= '0;
      m_rem       <= '0;
      m_full      <= '0;
    end else if (flush) begin
      if (busy_left > 0) begin
        exp_val <= cur_part[31:0];
        if (j >= 2) exp_carry <= cur_part[32];
        else        carry_known <= 1'b0;
      end
      busy_left <= 0;
      m_done    <= 1'b0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      j         <= j + 1;
      if (busy_left == 1) begin
        m_done      <= 1'b1;
        exp_val     <= m_full[31:0];
        exp_carry   <= m_full[32];
        carry_known <= 1'b1;
      end
    end else if (start) begin
      m_rm   <= val_rm;
      m_type <= shift_type;
      m_rem  <= cur_cls.amt;
      m_full <= {cur_cls.c, cur_cls.v};
      if (cur_cls.special) begin
        m_done      <= 1'b1;
        exp_val     <= cur_cls.v;
        exp_carry   <= cur_cls.c;
        carry_known <= 1'b1;
      end else begin
        m_done    <= 1'b0;
        busy_left <= (int'(cur_cls.amt) + STEP - 1) / STEP;
        j         <= 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("ready", 32'(ready), 32'(busy_left == 0));
      check("stall", 32'(stall), 32'((start && busy_left == 0 && !m_done) || busy_left > 0));
      check("done",  32'(done),  32'(m_done));
      if (busy_left > 0) begin
        check("val2_iter", val2, cur_part[31:0]);
        if (j >= 2) check("carry_iter", 32'(carry_out), 32'(cur_part[32]));
      end else begin
        check("val2", val2, exp_val);
        if (carry_known) check("carry", 32'(carry_out), 32'(exp_carry));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] t, input logic [31:0] rm,
                               input logic [7:0] n, input logic cin);
    @(posedge clk);
    #1;
    shift_type = t;
    val_rm     = rm;
    rs_amount  = n;
    carry_in   = cin;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called in cycle 1 after the accept edge; waits a bounded time for done.
  task automatic checkOutput(input string name, input logic [31:0] want_val,
                             input logic want_carry, input int want_lat);
    int cyc;
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc >= 40) begin
        check({name, "_timeout"}, 32'(done), 32'd1);
        return;
      end
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(want_lat));
    check({name, "_val2"}, val2, want_val);
    check({name, "_carry"}, 32'(carry_out), 32'(want_carry));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    shift_type = SH_LSL;
    val_rm     = '0;
    rs_amount  = '0;
    carry_in   = 1'b0;

    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_val2",  val2,       32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    start = 1'b1;
    #1;
    check("rst_stall_follows_start", 32'(stall), 32'd1);
    start = 1'b0;
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    applyStimulus(SH_LSL, 32'h0000_0001, 8'd20, 1'b0);
    checkOutput("lsl20", 32'h0010_0000, 1'b0, 4);
    applyStimulus(SH_LSR, 32'h8000_0000, 8'd32, 1'b0);
    checkOutput("lsr32", 32'h0000_0000, 1'b1, 1);
    applyStimulus(SH_LSR, 32'h8000_0000, 8'd33, 1'b1);
    checkOutput("lsr33", 32'h0000_0000, 1'b0, 1);
    applyStimulus(SH_ASR, 32'h8000_0000, 8'd4, 1'b1);
    checkOutput("asr4", 32'hF800_0000, 1'b0, 2);
    applyStimulus(SH_ASR, 32'h8000_0000, 8'd200, 1'b0);
    checkOutput("asr200", 32'hFFFF_FFFF, 1'b1, 1);
    applyStimulus(SH_ROR, 32'h0000_000F, 8'd36, 1'b0);
    checkOutput("ror36", 32'hF000_0000, 1'b1, 2);
    applyStimulus(SH_ROR, 32'h0000_000F, 8'd64, 1'b1);
    checkOutput("ror64", 32'h0000_000F, 1'b0, 1);
    applyStimulus(SH_ROR, 32'h0000_000F, 8'd0, 1'b1);
    checkOutput("ror0", 32'h0000_000F, 1'b1, 1);
    applyStimulus(SH_LSL, 32'hFFFF_FFFF, 8'd31, 1'b0);
    checkOutput("lsl31", 32'h8000_0000, 1'b1, 5);
    applyStimulus(SH_LSL, 32'h0000_0001, 8'd32, 1'b0);
    checkOutput("lsl32", 32'h0000_0000, 1'b1, 1);

    // Back-to-back: second request raised during the first DONE cycle.
    @(posedge clk);
    #1;
    shift_type = SH_LSR; val_rm = 32'h8000_0000; rs_amount = 8'd32; carry_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    shift_type = SH_ASR; rs_amount = 8'd200;
    @(negedge clk);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_val2", val2, 32'h0000_0000);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_val2", val2, 32'hFFFF_FFFF);

    // Flush in the second iterating cycle of LSL by 20.
    applyStimulus(SH_LSL, 32'h0000_0001, 8'd20, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_val2", val2, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      check("flush_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset pulse in the middle of an iterating operation.
    applyStimulus(SH_LSL, 32'h0000_0001, 8'd20, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_val2",  val2, 32'd0);
    check("arst_carry", 32'(carry_out), 32'd0);
    check("arst_done",  32'(done), 32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_stall", 32'(stall), 32'd0);
    #2;
    rst_n = 1'b1;

    // Randomized traffic, checked every cycle by the compare process.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      start      = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 15) == 0);
      shift_type = 2'($urandom);
      val_rm     = $urandom;
      carry_in   = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       rs_amount = 8'd0;
        1:       rs_amount = 8'd32;
        2:       rs_amount = 8'(33 + $urandom_range(0, 30));
        3:       rs_amount = 8'($urandom_range(1, 31));
        4:       rs_amount = 8'(32 * $urandom_range(1, 7));
        default: rs_amount = 8'($urandom);
      endcase
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
